// File: rtl/icache_if.sv
//------------------------------------------------------------------------------
// icache_if : fetcher and memory-controller signals of the instruction cache
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface icache_if;
    logic        ins_asked;
    logic [31:0] ins_addr;
    logic        ic_rdy;
    logic [31:0] ins;
    logic        ic_mem_req;
    logic [31:0] ic_mem_addr;
    logic        mem_ic_rdy;
    logic [31:0] mem_ic_data;

    modport slave (
        input  ins_asked, ins_addr, mem_ic_rdy, mem_ic_data,
        output ic_rdy, ins, ic_mem_req, ic_mem_addr
    );

    modport master (
        output ins_asked, ins_addr, mem_ic_rdy, mem_ic_data,
        input  ic_rdy, ins, ic_mem_req, ic_mem_addr
    );
endinterface

`default_nettype wire

// File: rtl/icache.sv
//------------------------------------------------------------------------------
// icache : direct-mapped read-only instruction cache, 4-word lines
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module icache #(
    parameter int INDEX_BITS = 5
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);
    localparam int TAG_BITS = 28 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [1:0]             k, k_next;
    logic [31:2]            cur_addr, cur_addr_next;
    logic                   rsp_valid, rsp_valid_next;
    logic [31:0]            rsp_data, rsp_data_next;
    logic                   mreq, mreq_next;
    logic [31:0]            maddr, maddr_next;
    logic                   fill_we;
    logic                   line_done;

    logic [LINES-1:0]       valid;
    logic [TAG_BITS-1:0]    tag_mem  [LINES];
    logic [31:0]            data_mem [LINES*4];

    logic [INDEX_BITS-1:0]  req_idx, cur_idx;
    logic [TAG_BITS-1:0]    req_tag, cur_tag;
    logic [1:0]             req_off;
    logic                   hit;
    logic                   unused_addr_bits;

    assign req_off = bus.ins_addr[3:2];
    assign req_idx = bus.ins_addr[4+INDEX_BITS-1:4];
    assign req_tag = bus.ins_addr[31:4+INDEX_BITS];
    assign cur_idx = cur_addr[4+INDEX_BITS-1:4];
    assign cur_tag = cur_addr[31:4+INDEX_BITS];
    assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    assign unused_addr_bits = &{1'b0, bus.ins_addr[1:0]};

    assign bus.ic_rdy      = rsp_valid;
    assign bus.ins         = rsp_data;
    assign bus.ic_mem_req  = mreq;
    assign bus.ic_mem_addr = maddr;

    always_comb begin
        state_next     = state;
        k_next         = k;
        cur_addr_next  = cur_addr;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data;
        mreq_next      = mreq;
        maddr_next     = maddr;
        fill_we        = 1'b0;
        line_done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ins_asked) begin
                    cur_addr_next = bus.ins_addr[31:2];
                    if (hit) begin
                        rsp_valid_next = 1'b1;
                        rsp_data_next  = data_mem[{req_idx, req_off}];
                    end else begin
                        k_next     = 2'd0;
                        state_next = REFILL;
                    end
                end
            end
            REFILL: begin
                // Request is dropped on every accepted word so each assertion fetches one word.
                if (!mreq) begin
                    mreq_next  = 1'b1;
                    maddr_next = {cur_addr[31:4], k, 2'b00};
                end else if (bus.mem_ic_rdy) begin
                    fill_we   = 1'b1;
                    mreq_next = 1'b0;
                    k_next    = k + 2'd1;
                    if (k == 2'd3) begin
                        line_done  = 1'b1;
                        state_next = RESPOND;
                    end
                end
            end
            RESPOND: begin
                rsp_valid_next = 1'b1;
                rsp_data_next  = data_mem[{cur_idx, cur_addr[3:2]}];
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k         <= 2'd0;
            cur_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            mreq      <= 1'b0;
            maddr     <= '0;
            valid     <= '0;
        end else if (rdy) begin
            k         <= k_next;
            cur_addr  <= cur_addr_next;
            rsp_valid <= rsp_valid_next;
            rsp_data  <= rsp_data_next;
            mreq      <= mreq_next;
            maddr     <= maddr_next;
            if (line_done) begin
                valid[cur_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && fill_we) begin
            data_mem[{cur_idx, k}] <= bus.mem_ic_data;
        end
        if (rdy && line_done) begin
            tag_mem[cur_idx] <= cur_tag;
        end
    end
endmodule

`default_nettype wire
